fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, instruction-memory address and the IF/ID
// pipeline register, with stall hold, bubble injection, redirect squash and a bubble counter.
//
// state  | meaning
// RUN    | normal fetch loaded IF/ID on the last edge
// HOLD   | stall held the PC (IF/ID held or bubbled)
// SQUASH | redirect loaded the target PC and a bubble
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        delay,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid,
   output logic [1:0]  fetch_state,
   output logic [15:0] bubble_count
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HOLD   = 2'd1,
      ST_SQUASH = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [15:0] bcnt_q, bcnt_d;
   logic [31:0] pc_plus4;
   logic        bubble_load;
   logic        unused_redirect_lsbs;

   // Targets are word aligned; the low address bits are dropped on purpose.
   assign unused_redirect_lsbs = ^redirect_pc[1:0];
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      pc4_d       = pc4_q;
      valid_d     = valid_q;
      bcnt_d      = bcnt_q;
      bubble_load = 1'b0;

      if (redirect_valid) begin
         pc_d        = {redirect_pc[31:2], 2'b00};
         bubble_load = 1'b1;
         state_d     = ST_SQUASH;
      end else if (stall) begin
         bubble_load = delay;
         state_d     = ST_HOLD;
      end else begin
         instr_d = imem_rdata;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
         pc_d    = pc_plus4;
         state_d = ST_RUN;
      end

      if (bubble_load) begin
         instr_d = NOP;
         pc4_d   = 32'd0;
         valid_d = 1'b0;
         if (bcnt_q != 16'hFFFF) begin
            bcnt_d = bcnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
         bcnt_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         bcnt_q  <= bcnt_d;
      end
   end

   assign imem_addr    = pc_q;
   assign ifid_instr   = instr_q;
   assign ifid_pc4     = pc4_q;
   assign ifid_valid   = valid_q;
   assign fetch_state  = state_q;
   assign bubble_count = bcnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver pushes model expectations, monitor pops and
// compares after each edge; a second instance covers a wrapping RESET_PC.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n, rst1_n;
   logic        stall, delay, redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr, imem_rdata, ifid_instr, ifid_pc4;
   logic        ifid_valid;
   logic [1:0]  fetch_state;
   logic [15:0] bubble_count;
   logic [31:0] imem_addr1, imem_rdata1, ifid_instr1, ifid_pc41;
   logic        ifid_valid1;
   logic [1:0]  fetch_state1;
   logic [15:0] bubble_count1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic [1:0]  st;
      logic [15:0] bc;
   } exp_t;

   exp_t sbq[$];

   // reference model state
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;
   int          m_st, m_bc;

   always #5 clk = ~clk;

   assign imem_rdata  = 32'h1000_0000 + imem_addr;
   assign imem_rdata1 = 32'h2000_0000 + imem_addr1;

   fetch_unit u_dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .delay(delay),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
      .fetch_state(fetch_state), .bubble_count(bubble_count)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst_n(rst1_n), .stall(stall), .delay(delay),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
      .ifid_instr(ifid_instr1), .ifid_pc4(ifid_pc41), .ifid_valid(ifid_valid1),
      .fetch_state(fetch_state1), .bubble_count(bubble_count1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic bubble();
      m_instr = 32'h0;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
      if (m_bc < 65535) m_bc = m_bc + 1;
   endtask

   // Apply one cycle of inputs at the falling edge and queue the expected outcome.
   task automatic drive(input logic r, input logic s, input logic d,
                        input logic rv, input logic [31:0] rp);
      exp_t e;
      @(negedge clk);
      rst_n = r; stall = s; delay = d; redirect_valid = rv; redirect_pc = rp;
      if (!r) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_st = 0; m_bc = 0;
      end else if (rv) begin
         m_pc = rp & 32'hFFFF_FFFC;
         bubble();
         m_st = 2;
      end else if (s) begin
         if (d) bubble();
         m_st = 1;
      end else begin
         m_instr = 32'h1000_0000 + m_pc;
         m_pc    = m_pc + 32'd4;
         m_pc4   = m_pc;
         m_valid = 1'b1;
         m_st    = 0;
      end
      e.addr = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
      e.st = 2'(m_st); e.bc = 16'(m_bc);
      sbq.push_back(e);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("imem_addr",    imem_addr,           e.addr);
            chk("ifid_instr",   ifid_instr,          e.instr);
            chk("ifid_pc4",     ifid_pc4,            e.pc4);
            chk("ifid_valid",   32'(ifid_valid),     32'(e.valid));
            chk("fetch_state",  32'(fetch_state),    32'(e.st));
            chk("bubble_count", 32'(bubble_count),   32'(e.bc));
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      rst_n = 1'b0; rst1_n = 1'b0; stall = 1'b0; delay = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;

      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_1234);
      run(4);

      // hold at PC=8 without bubbles, then release
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h8);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      run(2);

      // long multiply-style stall at PC=8
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h8);
      for (int i = 0; i < 32; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      run(2);

      // delay alone is ignored
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);

      // redirect beats stall, low bits dropped
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0043);
      run(1);

      // back-to-back redirect, then PC wrap past the top of memory
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
      run(2);

      // wrapping RESET_PC instance
      chk("wrap_reset_addr", imem_addr1, 32'hFFFF_FFFC);
      run(1);
      rst1_n = 1'b1;
      run(1);
      chk("wrap_addr0",  imem_addr1, 32'h0);
      chk("wrap_pc4_0",  ifid_pc41,  32'h0);
      chk("wrap_instr0", ifid_instr1, 32'h1FFF_FFFC);
      run(1);
      chk("wrap_addr1",  imem_addr1, 32'h4);
      chk("wrap_pc4_1",  ifid_pc41,  32'h4);
      chk("wrap_valid1", 32'(ifid_valid1), 32'h1);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
      rst1_n = 1'b0;
      run(1);
      chk("wrap_rst_addr",  imem_addr1, 32'hFFFF_FFFC);
      chk("wrap_rst_instr", ifid_instr1, 32'h0);
      chk("wrap_rst_pc4",   ifid_pc41, 32'h0);
      chk("wrap_rst_valid", 32'(ifid_valid1), 32'h0);
      chk("wrap_rst_state", 32'(fetch_state1), 32'h0);
      chk("wrap_rst_bc",    32'(bubble_count1), 32'h0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 39) != 0),
               ($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0),
               $urandom());
      end

      // saturation of the bubble counter
      for (int i = 0; i < 65540; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      run(1);

      k = 0;
      while (sbq.size() > 0 && k < 10) begin
         @(posedge clk);
         k++;
      end
      #2;
      chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
      chk("bubble_saturated", 32'(bubble_count), 32'h0000_FFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
